// File: rtl/perf_monitor.sv
`default_nettype none
// ============================================================================
// Module   : perf_monitor
// Brief    : Run-cycle and per-channel event counters with a cycle limit,
//            saturation, sticky overflow flags and a registered read port.
// Revision : 1.0 - initial release
// ============================================================================
module perf_monitor #(
    parameter int                NUM_EV    = 4,
    parameter int                CNT_W     = 32,
    parameter logic [NUM_EV-1:0] EDGE_MASK = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              freeze_i,
    input  logic              clear_i,
    input  logic [NUM_EV-1:0] event_i,
    input  logic [CNT_W-1:0]  limit_i,
    input  logic [3:0]        sel_i,
    output logic [CNT_W-1:0]  rd_data_o,
    output logic [CNT_W-1:0]  cycle_o,
    output logic [NUM_EV-1:0] ovf_o,
    output logic              running_o,
    output logic              done_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FROZEN = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_count;
    logic               w_zero;
    logic               w_limit_on;
    logic               w_limit_past;
    logic               w_limit_hit;
    logic [CNT_W-1:0]   r_cycle;
    logic [NUM_EV-1:0]  r_prev;
    logic [CNT_W-1:0]   w_ev_cnt [NUM_EV];
    logic [CNT_W-1:0]   w_rd;
    logic [CNT_W-1:0]   r_rd_data;

    assign w_zero       = rst_i | clear_i;
    assign w_limit_on   = |limit_i;
    assign w_limit_past = w_limit_on && (limit_i <= r_cycle);
    assign w_limit_hit  = w_limit_on && (r_cycle == (limit_i - CNT_W'(1)));

    always_ff @(posedge clk_i) begin
        if (w_zero) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A limit already reached (lowered mid-run) ends the run without counting.
    always_comb begin
        w_state_nxt = r_state;
        w_count     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_limit_past) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_count = 1'b1;
                    if (w_limit_hit)   w_state_nxt = S_DONE;
                    else if (freeze_i) w_state_nxt = S_FROZEN;
                end
            end
            S_FROZEN: begin
                if (!freeze_i) w_state_nxt = S_RUN;
            end
            S_DONE: begin
                w_state_nxt = S_DONE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (w_zero) begin
            r_cycle <= '0;
            r_prev  <= '0;
        end else begin
            r_prev <= event_i;
            if (w_count && (r_cycle != c_cnt_max)) r_cycle <= r_cycle + CNT_W'(1);
        end
    end

    generate
        for (genvar k = 0; k < NUM_EV; k++) begin : g_ch
            logic             w_qual;
            logic [CNT_W-1:0] r_cnt;
            logic             r_ovf;

            assign w_qual = event_i[k] & (~EDGE_MASK[k] | ~r_prev[k]);

            always_ff @(posedge clk_i) begin
                if (w_zero) begin
                    r_cnt <= '0;
                    r_ovf <= 1'b0;
                end else if (w_count && w_qual) begin
                    if (r_cnt == c_cnt_max) r_ovf <= 1'b1;
                    else                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            assign w_ev_cnt[k] = r_cnt;
            assign ovf_o[k]    = r_ovf;
        end
    endgenerate

    always_comb begin
        w_rd = '0;
        if (sel_i == 4'd0) begin
            w_rd = r_cycle;
        end else begin
            for (int k = 0; k < NUM_EV; k++) begin
                if (int'(sel_i) == k + 1) w_rd = w_ev_cnt[k];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_zero) r_rd_data <= '0;
        else        r_rd_data <= w_rd;
    end

    assign rd_data_o = r_rd_data;
    assign cycle_o   = r_cycle;
    assign running_o = (r_state == S_RUN);
    assign done_o    = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_perf_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_perf_monitor
// Brief    : Self-checking bench for perf_monitor (32-bit edge-mixed and
//            4-bit saturating instances) against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_perf_monitor;

    logic        clk = 1'b0;
    logic        rst, start, freeze, clear;
    logic [3:0]  ev;
    logic [31:0] lim;
    logic [3:0]  sel;

    logic [31:0] d_rd, d_cyc;
    logic [3:0]  d_ovf;
    logic        d_run, d_done;
    logic [3:0]  s_rd, s_cyc;
    logic [3:0]  s_ovf;
    logic        s_run, s_done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    perf_monitor #(.NUM_EV(4), .CNT_W(32), .EDGE_MASK(4'b0010)) u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .freeze_i(freeze), .clear_i(clear),
        .event_i(ev), .limit_i(lim), .sel_i(sel), .rd_data_o(d_rd), .cycle_o(d_cyc),
        .ovf_o(d_ovf), .running_o(d_run), .done_o(d_done)
    );

    perf_monitor #(.NUM_EV(4), .CNT_W(4), .EDGE_MASK(4'b0000)) u_sat (
        .clk_i(clk), .rst_i(rst), .start_i(start), .freeze_i(freeze), .clear_i(clear),
        .event_i(ev), .limit_i(4'd0), .sel_i(sel), .rd_data_o(s_rd), .cycle_o(s_cyc),
        .ovf_o(s_ovf), .running_o(s_run), .done_o(s_done)
    );

    // Behavioural model: phase 0 idle, 1 run, 2 frozen, 3 done.
    int          m_ph   [2];
    longint      m_cyc  [2];
    longint      m_cnt  [2][4];
    logic [3:0]  m_ovf  [2];
    longint      m_rd   [2];
    logic [3:0]  m_prev;
    longint      m_max  [2] = '{64'hFFFF_FFFF, 64'hF};
    logic [3:0]  m_edge [2] = '{4'b0010, 4'b0000};

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            longint l = (i == 0) ? longint'(lim) : 0;
            bit     cnt_en = 1'b0;
            if (rst || clear) begin
                m_ph[i] = 0; m_cyc[i] = 0; m_ovf[i] = '0; m_rd[i] = 0;
                for (int k = 0; k < 4; k++) m_cnt[i][k] = 0;
            end else begin
                if (sel == 0)      m_rd[i] = m_cyc[i];
                else if (sel <= 4) m_rd[i] = m_cnt[i][sel-1];
                else               m_rd[i] = 0;
                if (m_ph[i] == 0) begin
                    if (start) m_ph[i] = 1;
                end else if (m_ph[i] == 1) begin
                    if (l != 0 && l <= m_cyc[i]) m_ph[i] = 3;
                    else begin
                        cnt_en = 1'b1;
                        if (l != 0 && m_cyc[i] + 1 == l) m_ph[i] = 3;
                        else if (freeze)                 m_ph[i] = 2;
                    end
                end else if (m_ph[i] == 2) begin
                    if (!freeze) m_ph[i] = 1;
                end
                if (cnt_en) begin
                    if (m_cyc[i] < m_max[i]) m_cyc[i]++;
                    for (int k = 0; k < 4; k++) begin
                        if (ev[k] && !(m_edge[i][k] && m_prev[k])) begin
                            if (m_cnt[i][k] == m_max[i]) m_ovf[i][k] = 1'b1;
                            else                         m_cnt[i][k]++;
                        end
                    end
                end
            end
        end
        m_prev = (rst || clear) ? 4'b0 : ev;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("d_running", longint'(d_run),  longint'(m_ph[0] == 1));
        check("d_done",    longint'(d_done), longint'(m_ph[0] == 3));
        check("d_cycle",   longint'(d_cyc),  m_cyc[0]);
        check("d_ovf",     longint'(d_ovf),  longint'(m_ovf[0]));
        check("d_rd_data", longint'(d_rd),   m_rd[0]);
        check("s_running", longint'(s_run),  longint'(m_ph[1] == 1));
        check("s_done",    longint'(s_done), longint'(m_ph[1] == 3));
        check("s_cycle",   longint'(s_cyc),  m_cyc[1]);
        check("s_ovf",     longint'(s_ovf),  longint'(m_ovf[1]));
        check("s_rd_data", longint'(s_rd),   m_rd[1]);
    endtask

    task automatic idle_inputs();
        rst = 0; start = 0; freeze = 0; clear = 0; ev = '0; lim = '0; sel = '0;
    endtask

    typedef struct {
        logic        rst, start, freeze, clear;
        logic [3:0]  ev;
        logic [31:0] lim;
        logic [3:0]  sel;
        logic        exp_run, exp_done;
        logic [31:0] exp_cyc, exp_rd;
    } vec_t;

    vec_t vt [10];

    initial begin
        int n;
        idle_inputs();
        rst = 1;
        m_prev = '0;
        for (int i = 0; i < 2; i++) begin
            m_ph[i] = 0; m_cyc[i] = 0; m_ovf[i] = '0; m_rd[i] = 0;
            for (int k = 0; k < 4; k++) m_cnt[i][k] = 0;
        end

        // Short run to a limit of 3, DONE hold, out-of-range read, clear+start.
        vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0, 32'd0};
        vt[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h1, 32'd3, 4'd0, 1'b1, 1'b0, 32'd0, 32'd0};
        vt[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 32'd3, 4'd1, 1'b1, 1'b0, 32'd1, 32'd0};
        vt[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 32'd3, 4'd1, 1'b1, 1'b0, 32'd2, 32'd1};
        vt[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 32'd3, 4'd1, 1'b0, 1'b1, 32'd3, 32'd2};
        vt[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 32'd3, 4'd1, 1'b0, 1'b1, 32'd3, 32'd3};
        vt[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 32'd3, 4'd0, 1'b0, 1'b1, 32'd3, 32'd3};
        vt[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'd3, 4'd7, 1'b0, 1'b1, 32'd3, 32'd0};
        vt[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 32'd3, 4'd0, 1'b0, 1'b0, 32'd0, 32'd0};
        vt[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'd3, 4'd1, 1'b0, 1'b0, 32'd0, 32'd0};
        for (int i = 0; i < 10; i++) begin
            rst = vt[i].rst; start = vt[i].start; freeze = vt[i].freeze; clear = vt[i].clear;
            ev = vt[i].ev; lim = vt[i].lim; sel = vt[i].sel;
            tick();
            check("vec_running", longint'(d_run),  longint'(vt[i].exp_run));
            check("vec_done",    longint'(d_done), longint'(vt[i].exp_done));
            check("vec_cycle",   longint'(d_cyc),  longint'(vt[i].exp_cyc));
            check("vec_rd_data", longint'(d_rd),   longint'(vt[i].exp_rd));
        end

        // Limit of 30 with channel 0 held high.
        idle_inputs(); rst = 1; tick();
        rst = 0; start = 1; ev = 4'b0001; lim = 32'd30; tick();
        start = 0; n = 0;
        for (int t = 0; t < 40 && !d_done; t++) begin
            if (d_run) n++;
            tick();
        end
        check("limit_done_seen", longint'(d_done), 1);
        check("limit_run_cycles", n, 30);
        check("limit_cycle", longint'(d_cyc), 30);
        sel = 4'd1; tick();
        check("limit_ch0", longint'(d_rd), 30);

        // Edge versus level counting.
        idle_inputs(); clear = 1; tick();
        clear = 0; start = 1; tick();
        start = 0;
        for (int t = 0; t < 8; t++) begin ev = (t % 2 == 0) ? 4'b0011 : 4'b0000; tick(); end
        ev = 0; freeze = 1; tick();
        sel = 4'd1; tick(); check("toggle_ch0", longint'(d_rd), 4);
        sel = 4'd2; tick(); check("toggle_ch1", longint'(d_rd), 4);
        freeze = 0; tick();
        ev = 4'b0011;
        for (int t = 0; t < 8; t++) tick();
        ev = 0; freeze = 1; tick();
        sel = 4'd1; tick(); check("hold_ch0", longint'(d_rd), 12);
        sel = 4'd2; tick(); check("hold_ch1", longint'(d_rd), 5);

        // Freeze for 5 edges mid-run.
        idle_inputs(); clear = 1; tick();
        clear = 0; start = 1; ev = 4'b1111; tick();
        start = 0;
        for (int t = 0; t < 10; t++) tick();
        freeze = 1;
        for (int t = 0; t < 5; t++) begin tick(); check("freeze_running", longint'(d_run), 0); end
        freeze = 0;
        for (int t = 0; t < 5; t++) tick();
        check("freeze_cycle", longint'(d_cyc), 15);

        // Saturation of the 4-bit instance.
        idle_inputs(); clear = 1; tick();
        clear = 0; start = 1; tick();
        start = 0; ev = 4'b0100;
        for (int t = 0; t < 20; t++) tick();
        ev = 0; sel = 4'd3; tick();
        check("sat_ch2", longint'(s_rd), 15);
        check("sat_ovf", longint'(s_ovf), 4);
        clear = 1; tick();
        check("sat_clear_ovf", longint'(s_ovf), 0);
        check("sat_clear_run", longint'(s_run), 0);

        // Reset mid-run.
        idle_inputs(); start = 1; tick();
        start = 0; ev = 4'b1111;
        for (int t = 0; t < 5; t++) tick();
        rst = 1; tick();
        check("rst_cycle", longint'(d_cyc), 0);
        check("rst_ovf",   longint'(s_ovf), 0);
        check("rst_rd",    longint'(d_rd), 0);
        check("rst_run",   longint'(d_run), 0);

        // Randomized traffic.
        idle_inputs();
        for (int t = 0; t < 600; t++) begin
            rst    = ($urandom_range(0, 149) == 0);
            clear  = ($urandom_range(0, 59) == 0);
            start  = ($urandom_range(0, 3) == 0);
            freeze = ($urandom_range(0, 5) == 0);
            ev     = 4'($urandom);
            sel    = 4'($urandom_range(0, 7));
            if ($urandom_range(0, 24) == 0)
                lim = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 60));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/perf_monitor.md
# perf_monitor

Synthesizable event/cycle performance counter for the pipelined CPU. It replaces bench-side stall/flush counting with hardware counters. It counts run cycles and up to NUM_EV per-channel events, in level or rising-edge mode, with saturation and sticky overflow flags. Counting stops automatically at a programmable cycle limit. The CPU top instantiates it beside the hazard unit; benches and debug logic read results through a registered select port.

## Interface
Parameters:
- NUM_EV, 4, number of event channels (1..15)
- CNT_W, 32, width of every counter
- EDGE_MASK, 0, NUM_EV-bit mask; bit k=1 makes channel k count rising edges, 0 makes it count high cycles

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- start_i  in  1  leave IDLE and begin counting
- freeze_i  in  1  pause counting while high (RUN only)
- clear_i  in  1  zero all counters and flags, return to IDLE
- event_i  in  NUM_EV  per-channel event inputs, e.g. stall, flush, branch, retire
- limit_i  in  CNT_W  cycle limit; 0 means no limit; sampled every cycle
- sel_i  in  4  read select: 0 selects the cycle counter; k in 1..NUM_EV selects event counter k-1
- rd_data_o  out  CNT_W  registered read data
- cycle_o  out  CNT_W  live cycle counter
- ovf_o  out  NUM_EV  sticky per-channel saturation flags
- running_o  out  1  high in RUN
- done_o  out  1  high in DONE

## Operation
- States: IDLE, RUN, FROZEN, DONE. Reset and clear_i enter IDLE.
- IDLE: all counters hold. start_i=1 moves to RUN at the next edge. No counting in the cycle where start_i is sampled.
- RUN:
  - cycle counter +1 every cycle.
  - Channel k +1 when its qualifier is true. Level mode: event_i[k]=1. Edge mode: event_i[k]=1 and prev[k]=0.
  - freeze_i=1 moves to FROZEN. The cycle in which freeze_i is sampled is still counted.
- FROZEN: nothing counts. freeze_i=0 returns to RUN.
- Limit: in RUN with limit_i≠0 and cycle count == limit_i-1, the edge writes cycle count = limit_i, counts that cycle's events, and moves to DONE. The count therefore stops at exactly limit_i cycles.
- limit_i≤cycle count while in RUN (limit lowered mid-run): move to DONE at the next edge with no increment.
- DONE: everything holds. start_i and freeze_i are ignored. Only clear_i or rst_i leave DONE.
- Saturation: a counter at all-ones stays at all-ones. An event qualifier true while saturated sets ovf_o[k]; the flag is sticky until clear/reset. The cycle counter saturates silently.
- prev[k] registers event_i[k] every cycle in every state, including FROZEN and DONE. An edge that spans a freeze is therefore not counted after unfreeze.
- Priority: rst_i > clear_i > limit reached > freeze_i > start_i.
- Read: rd_data_o <= counter[sel_i] each cycle. sel_i > NUM_EV returns 0.

## Timing
- Reset values:
  - all counters 0, prev 0
  - rd_data_o 0, cycle_o 0, ovf_o 0
  - running_o 0, done_o 0
  - state IDLE
- clear_i has the same effect as reset and the same one-edge latency, in any state.
- running_o and done_o are decoded from the state register, so they change on the edge of the transition.
- rd_data_o latency is 1 cycle after sel_i. It reflects counter values from before the concurrent increment.
- An event present on the edge entering RUN is not counted. The first counted cycle is the first cycle with running_o=1.
- start_i and clear_i in the same cycle: clear wins, state stays IDLE.
- freeze_i and limit reached in the same cycle: DONE.
- Reset mid-RUN discards all counts.

## Test plan
- Reset, then start_i pulse, limit_i=30, event_i[0] held high → done_o rises after exactly 30 running cycles; cycle_o=30 and channel 0 reads 30 via sel_i=1 one cycle later.
- EDGE_MASK=4'b0010, event_i[1] toggling 1,0,1,0 for 8 RUN cycles while event_i[0] follows the same pattern → channel 1=4 and channel 0=4. Holding both high for 8 cycles → channel 1=1 and channel 0=8.
- freeze_i high for 5 cycles mid-run with limit_i=0 and events high → counters advance by (run cycles − 5) only; running_o=0 during the freeze.
- CNT_W=4, event_i[2] high for 20 cycles → channel 2 holds 15, ovf_o[2]=1, other ovf bits 0. A clear_i pulse → all zero and IDLE.
- In DONE, drive start_i and freeze_i → no change. In IDLE, drive start_i and clear_i together → stays IDLE with zeros.
- Set sel_i=7 with NUM_EV=4 → rd_data_o=0. Assert rst_i mid-RUN → all outputs return to their reset values after one edge.
